// File: rtl/rtc_pkg.sv
// Shared types and constants for the time-of-day counter.
// Holds the RUN/EDIT state enum, field-select codes, BCD/hour limits and
// the hour-to-BCD display decode used by rtc_counter.
package rtc_pkg;

  localparam int unsigned BCD_W = 4;
  localparam int unsigned HR_W  = 5;
  localparam int unsigned SEL_W = 2;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_EDIT = 1'b1
  } state_t;

  localparam logic [SEL_W-1:0] SEL_SEC  = 2'd0;
  localparam logic [SEL_W-1:0] SEL_MIN  = 2'd1;
  localparam logic [SEL_W-1:0] SEL_HR   = 2'd2;
  localparam logic [SEL_W-1:0] SEL_NONE = 2'd3;

  localparam logic [BCD_W-1:0] BCD_MAX_TENS  = 4'd5;
  localparam logic [BCD_W-1:0] BCD_MAX_UNITS = 4'd9;
  localparam logic [HR_W-1:0]  HR_MAX        = 5'd23;

  // Binary hour (0-23) to {tens, units} BCD, optionally folded to 12-hour form.
  function automatic logic [2*BCD_W-1:0] hr_to_bcd(input logic [HR_W-1:0] hr,
                                                   input logic            mode_12h);
    logic [HR_W-1:0] h;
    h = hr;
    if (mode_12h) begin
      if (hr == '0)          h = 5'd12;
      else if (hr > 5'd12)   h = hr - 5'd12;
    end
    if (h >= 5'd20)      return {4'd2, 4'(h - 5'd20)};
    else if (h >= 5'd10) return {4'd1, 4'(h - 5'd10)};
    else                 return {4'd0, 4'(h)};
  endfunction

endpackage

// File: rtl/bcd_mod60.sv
// Two-digit BCD counter 00-59.
// Ports: clk/reset (sync, active-high); inc/dec step with wrap and no carry;
// carry_in advances like inc; carry_out flags carry_in arriving at 59.
module bcd_mod60
  import rtc_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  input  logic             carry_in,
  output logic [BCD_W-1:0] tens,
  output logic [BCD_W-1:0] units,
  output logic             carry_out
);

  logic [BCD_W-1:0] r_tens;
  logic [BCD_W-1:0] r_units;
  logic             w_up;
  logic             w_at_max;

  assign w_up      = inc || (carry_in && !dec);
  assign w_at_max  = (r_tens == BCD_MAX_TENS) && (r_units == BCD_MAX_UNITS);
  assign carry_out = carry_in && w_at_max;
  assign tens      = r_tens;
  assign units     = r_units;

  // Digit update: up-count wraps 59->00, down-count wraps 00->59.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tens  <= '0;
      r_units <= '0;
    end else if (w_up) begin
      if (r_units == BCD_MAX_UNITS) begin
        r_units <= '0;
        r_tens  <= (r_tens == BCD_MAX_TENS) ? '0 : r_tens + 4'd1;
      end else begin
        r_units <= r_units + 4'd1;
      end
    end else if (dec) begin
      if (r_units == '0) begin
        r_units <= BCD_MAX_UNITS;
        r_tens  <= (r_tens == '0) ? BCD_MAX_TENS : r_tens - 4'd1;
      end else begin
        r_units <= r_units - 4'd1;
      end
    end
  end

endmodule

// File: rtl/rtc_counter.sv
// Time-of-day counter with one-second prescaler and RUN/EDIT state machine.
// Ports: CLOCK_50, reset (sync, active-high); mode_12h, sel, inc, dec, resume
// in; BCD digits sec/min (registered), hr_h/hr_l/pm decoded from the hour
// register; state (0 RUN, 1 EDIT); one_sec tick; change pulse.
// Optional alarm (alarm_edit, alarm_on, alarm_hit) under macro RTC_ALARM_EN.
module rtc_counter
  import rtc_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50000000
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             mode_12h,
  input  logic [SEL_W-1:0] sel,
  input  logic             inc,
  input  logic             dec,
  input  logic             resume,
  output logic [BCD_W-1:0] sec_l,
  output logic [BCD_W-1:0] sec_h,
  output logic [BCD_W-1:0] min_l,
  output logic [BCD_W-1:0] min_h,
  output logic [BCD_W-1:0] hr_l,
  output logic [BCD_W-1:0] hr_h,
  output logic             pm,
  output logic             state,
  output logic             one_sec,
`ifdef RTC_ALARM_EN
  input  logic             alarm_edit,
  input  logic             alarm_on,
  output logic             alarm_hit,
`endif
  output logic             change
);

  localparam int unsigned PW = $clog2(CLK_HZ);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PW-1:0]   r_presc;
  logic [HR_W-1:0] r_hr;
  logic            r_change;
  logic            w_one_sec;
  logic            w_req;
  logic            w_tick;
  logic            w_time_sel;
  logic            w_sec_co;
  logic            w_min_co;
  logic            w_hr_inc;
  logic            w_hr_dec;

`ifdef RTC_ALARM_EN
  // Alarm edits bypass the time registers and the FSM entirely.
  assign w_time_sel = !alarm_edit;
`else
  assign w_time_sel = 1'b1;
`endif

  // Valid time edit: exactly one direction and a real field.
  assign w_req     = (inc ^ dec) && (sel != SEL_NONE) && w_time_sel;
  assign w_one_sec = (r_state == ST_RUN) && (r_presc == PW'(CLK_HZ - 1));
  // An edit in the same cycle as a tick wins; the tick is dropped.
  assign w_tick    = w_one_sec && !w_req;
  assign w_hr_inc  = w_req && inc && (sel == SEL_HR);
  assign w_hr_dec  = w_req && dec && (sel == SEL_HR);

  bcd_mod60 u_sec (
    .clk       (CLOCK_50),
    .reset     (reset),
    .inc       (w_req && inc && (sel == SEL_SEC)),
    .dec       (w_req && dec && (sel == SEL_SEC)),
    .carry_in  (w_tick),
    .tens      (sec_h),
    .units     (sec_l),
    .carry_out (w_sec_co)
  );

  bcd_mod60 u_min (
    .clk       (CLOCK_50),
    .reset     (reset),
    .inc       (w_req && inc && (sel == SEL_MIN)),
    .dec       (w_req && dec && (sel == SEL_MIN)),
    .carry_in  (w_sec_co),
    .tens      (min_h),
    .units     (min_l),
    .carry_out (w_min_co)
  );

  // Hour register: edits wrap 0..23, carry from minutes advances it.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_hr <= '0;
    end else if (w_hr_inc || (w_min_co && !w_hr_dec)) begin
      r_hr <= (r_hr == HR_MAX) ? '0 : r_hr + 5'd1;
    end else if (w_hr_dec) begin
      r_hr <= (r_hr == '0) ? HR_MAX : r_hr - 5'd1;
    end
  end

  // FSM state register.
  always_ff @(posedge CLOCK_50) begin
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_state_nxt;
  end

  // FSM next state.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_RUN:  if (w_req)  w_state_nxt = ST_EDIT;
      ST_EDIT: if (resume) w_state_nxt = ST_RUN;
    endcase
  end

  // Prescaler is parked at 0 for the whole EDIT stay so RUN restarts a full second.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_presc <= '0;
    end else if ((r_state == ST_EDIT) || (w_state_nxt == ST_EDIT)) begin
      r_presc <= '0;
    end else if (r_presc == PW'(CLK_HZ - 1)) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  // Change strobe marks the first cycle a new time value is visible.
  always_ff @(posedge CLOCK_50) begin
    if (reset) r_change <= 1'b0;
    else       r_change <= w_tick || w_req;
  end

  assign {hr_h, hr_l} = hr_to_bcd(r_hr, mode_12h);
  assign pm           = (r_hr >= 5'd12);
  assign state        = (r_state == ST_EDIT);
  assign one_sec      = w_one_sec;
  assign change       = r_change;

`ifdef RTC_ALARM_EN
  logic [BCD_W-1:0] w_al_min_h;
  logic [BCD_W-1:0] w_al_min_l;
  logic             w_al_co;
  logic [HR_W-1:0]  r_al_hr;
  logic             r_tick_d;
  logic             w_al_req;

  assign w_al_req = alarm_edit && (inc ^ dec) && ((sel == SEL_MIN) || (sel == SEL_HR));

  bcd_mod60 u_al_min (
    .clk       (CLOCK_50),
    .reset     (reset),
    .inc       (w_al_req && inc && (sel == SEL_MIN)),
    .dec       (w_al_req && dec && (sel == SEL_MIN)),
    .carry_in  (1'b0),
    .tens      (w_al_min_h),
    .units     (w_al_min_l),
    .carry_out (w_al_co)
  );

  // Alarm hour and the delayed tick used to qualify a match.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_al_hr  <= '0;
      r_tick_d <= 1'b0;
    end else begin
      r_tick_d <= w_tick;
      if (w_al_req && inc && (sel == SEL_HR))
        r_al_hr <= (r_al_hr == HR_MAX) ? '0 : r_al_hr + 5'd1;
      else if (w_al_req && dec && (sel == SEL_HR))
        r_al_hr <= (r_al_hr == '0) ? HR_MAX : r_al_hr - 5'd1;
    end
  end

  // Hit in the cycle the ticked time HH:MM:00 first becomes visible.
  assign alarm_hit = r_tick_d && alarm_on && !w_al_co &&
                     (sec_h == '0) && (sec_l == '0) &&
                     (min_h == w_al_min_h) && (min_l == w_al_min_l) &&
                     (r_hr == r_al_hr);
`endif

endmodule

// File: tb/tb_rtc_counter.sv
// Directed bench for rtc_counter at CLK_HZ=4 with a queue scoreboard and a
// reference time model kept in integers.
module tb_rtc_counter;

  localparam int unsigned CLK_HZ = 4;

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b1;
  logic       mode_12h = 1'b0;
  logic [1:0] sel      = 2'd3;
  logic       inc      = 1'b0;
  logic       dec      = 1'b0;
  logic       resume   = 1'b0;
  logic [3:0] sec_l, sec_h, min_l, min_h, hr_l, hr_h;
  logic       pm, state, one_sec, change;

  rtc_counter #(.CLK_HZ(CLK_HZ)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .mode_12h (mode_12h),
    .sel      (sel),
    .inc      (inc),
    .dec      (dec),
    .resume   (resume),
    .sec_l    (sec_l),
    .sec_h    (sec_h),
    .min_l    (min_l),
    .min_h    (min_h),
    .hr_l     (hr_l),
    .hr_h     (hr_h),
    .pm       (pm),
    .state    (state),
    .one_sec  (one_sec),
    .change   (change)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t sb[$];
  int  n_assert = 0;
  int  n_fail   = 0;
  int  m_hr = 0, m_min = 0, m_sec = 0;

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic push(input string tag, input logic [31:0] exp);
    sb_t it;
    it.tag = tag;
    it.exp = exp;
    sb.push_back(it);
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    sb_t it;
    n_assert++;
    assert (sb.size() != 0) else begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%0d expected=queued_value", obs);
    end
    if (sb.size() != 0) begin
      it = sb.pop_front();
      assert (obs === it.exp) else begin
        n_fail++;
        $error("FAIL %s observed=%0d expected=%0d", it.tag, obs, it.exp);
      end
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    push(tag, {31'd0, exp});
    pop_cmp({31'd0, obs});
  endtask

  function automatic int disp_hr(input int h, input logic m12);
    if (!m12)   return h;
    if (h == 0) return 12;
    if (h > 12) return h - 12;
    return h;
  endfunction

  // Expected digits come from the integer model, observed from the DUT pins.
  task automatic check_time(input string tag);
    int dh;
    dh = disp_hr(m_hr, mode_12h);
    push({tag, ".sec_l"}, 32'(m_sec % 10));
    push({tag, ".sec_h"}, 32'(m_sec / 10));
    push({tag, ".min_l"}, 32'(m_min % 10));
    push({tag, ".min_h"}, 32'(m_min / 10));
    push({tag, ".hr_l"},  32'(dh % 10));
    push({tag, ".hr_h"},  32'(dh / 10));
    push({tag, ".pm"},    32'(m_hr >= 12));
    pop_cmp({28'd0, sec_l});
    pop_cmp({28'd0, sec_h});
    pop_cmp({28'd0, min_l});
    pop_cmp({28'd0, min_h});
    pop_cmp({28'd0, hr_l});
    pop_cmp({28'd0, hr_h});
    pop_cmp({31'd0, pm});
  endtask

  task automatic model_tick();
    m_sec++;
    if (m_sec == 60) begin
      m_sec = 0;
      m_min++;
      if (m_min == 60) begin
        m_min = 0;
        m_hr  = (m_hr + 1) % 24;
      end
    end
  endtask

  // Back-to-back edit pulses, one step each, model updated per pulse.
  task automatic edit(input logic [1:0] s, input bit up, input int n);
    for (int k = 0; k < n; k++) begin
      sel = s;
      inc = up;
      dec = !up;
      step();
      case (s)
        2'd0: m_sec = (m_sec + (up ? 1 : 59)) % 60;
        2'd1: m_min = (m_min + (up ? 1 : 59)) % 60;
        2'd2: m_hr  = (m_hr  + (up ? 1 : 23)) % 24;
        default: ;
      endcase
    end
    inc = 1'b0;
    dec = 1'b0;
    sel = 2'd3;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    step();
    step();
    check_time("rst24");
    chk("rst.state", state, 1'b0);
    chk("rst.change", change, 1'b0);
    chk("rst.one_sec", one_sec, 1'b0);
    mode_12h = 1'b1;
    #1;
    check_time("rst12");
    mode_12h = 1'b0;
    reset = 1'b0;

    // Free run: ticks in cycles 4 and 8, change one cycle after each.
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("run.one_sec.c%0d", c), one_sec, (c % 4) == 0);
      chk($sformatf("run.change.c%0d", c), change, c == 5);
      if ((c % 4) == 0) model_tick();
      step();
    end
    check_time("run8");
    chk("run8.change", change, 1'b1);

    // Hour decrement from 0 enters EDIT; 12h view of 23.
    edit(2'd2, 1'b0, 1);
    chk("hrdec.state", state, 1'b1);
    chk("hrdec.change", change, 1'b1);
    mode_12h = 1'b1;
    #1;
    check_time("hr23_12h");
    mode_12h = 1'b0;

    edit(2'd1, 1'b0, 1);
    edit(2'd0, 1'b0, 3);
    check_time("pre235959");
    edit(2'd0, 1'b1, 1);
    check_time("secwrap_no_carry");
    edit(2'd0, 1'b0, 1);
    check_time("back235959");

    for (int c = 0; c < 20; c++) begin
      chk($sformatf("edit_hold.one_sec.%0d", c), one_sec, 1'b0);
      step();
    end
    chk("edit_hold.state", state, 1'b1);
    chk("edit_hold.change", change, 1'b0);

    // Resume: first tick a full period later, rolls 23:59:59 to 00:00:00.
    resume = 1'b1;
    step();
    resume = 1'b0;
    chk("resume.state", state, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("resume.one_sec.c%0d", c), one_sec, c == 4);
      chk($sformatf("resume.change.c%0d", c), change, 1'b0);
      if (c == 4) model_tick();
      step();
    end
    check_time("wrap000000");
    chk("wrap.change", change, 1'b1);
    step();
    chk("wrap.change_once", change, 1'b0);

    // Ignored requests: inc+dec together, then sel=3.
    sel = 2'd1;
    inc = 1'b1;
    dec = 1'b1;
    step();
    inc = 1'b0;
    dec = 1'b0;
    sel = 2'd3;
    chk("both.state", state, 1'b0);
    chk("both.change", change, 1'b0);
    check_time("both");
    inc = 1'b1;
    step();
    inc = 1'b0;
    chk("selnone.state", state, 1'b0);
    chk("selnone.change", change, 1'b0);
    chk("selnone.one_sec", one_sec, 1'b1);

    // Edit coinciding with a tick wins and drops the tick.
    edit(2'd1, 1'b1, 1);
    check_time("prio");
    chk("prio.state", state, 1'b1);
    chk("prio.change", change, 1'b1);
    chk("prio.one_sec", one_sec, 1'b0);

    edit(2'd2, 1'b1, 12);
    edit(2'd1, 1'b1, 33);
    edit(2'd0, 1'b0, 4);
    check_time("t123456");
    mode_12h = 1'b1;
    #1;
    check_time("t123456_12h");
    mode_12h = 1'b0;

    // Reset in EDIT with pending pulses.
    reset  = 1'b1;
    sel    = 2'd0;
    inc    = 1'b1;
    resume = 1'b1;
    step();
    reset  = 1'b0;
    inc    = 1'b0;
    resume = 1'b0;
    sel    = 2'd3;
    m_hr = 0;
    m_min = 0;
    m_sec = 0;
    check_time("rst_edit");
    chk("rst_edit.state", state, 1'b0);
    chk("rst_edit.change", change, 1'b0);
    chk("rst_edit.one_sec", one_sec, 1'b0);

    resume = 1'b1;
    step();
    resume = 1'b0;
    chk("resume_in_run.state", state, 1'b0);
    chk("resume_in_run.change", change, 1'b0);
    check_time("resume_in_run");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
